// File: rtl/hash_bits_off_dispatcher.sv
// Front-end and result collector for the bits-off counter: XORs accepted candidate
// hashes with a loaded target, strobes the counter, and tracks the best candidate.
module hash_bits_off_dispatcher #(
    parameter int HASH_W = 1024,
    parameter int ID_W   = 64,
    parameter int BITS_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [HASH_W-1:0] target_i,
    input  logic              target_load_i,
    input  logic [HASH_W-1:0] hash_i,
    input  logic [ID_W-1:0]   hash_id_i,
    input  logic              hash_valid_i,
    output logic              hash_ready_o,
    output logic [HASH_W-1:0] hash_xor_o,
    output logic              new_hash_ready_o,
    input  logic [BITS_W-1:0] counter_bits_off_i,
    input  logic              counter_done_i,
    output logic              result_valid_o,
    output logic [BITS_W-1:0] result_bits_off_o,
    output logic [ID_W-1:0]   result_id_o,
    input  logic              clear_best_i,
    output logic              best_valid_o,
    output logic [BITS_W-1:0] best_bits_off_o,
    output logic [ID_W-1:0]   best_id_o,
    output logic              best_update_o
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        ARM       = 3'd2,
        WAIT_DONE = 3'd3,
        COMPARE   = 3'd4
    } state_t;

    state_t              state_r;
    state_t              next_state_s;
    logic                hash_ready_s;
    logic                strobe_s;
    logic                capture_s;
    logic                result_valid_s;
    logic                accept_s;
    logic                better_s;
    logic                best_update_s;
    logic [HASH_W-1:0]   target_r;
    logic [HASH_W-1:0]   hash_xor_r;
    logic [ID_W-1:0]     id_r;
    logic [BITS_W-1:0]   result_bits_r;
    logic                best_valid_r;
    logic [BITS_W-1:0]   best_bits_r;
    logic [ID_W-1:0]     best_id_r;

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; ARM deliberately ignores done so a stale level is never sampled
    always_comb begin
        next_state_s   = state_r;
        hash_ready_s   = 1'b0;
        strobe_s       = 1'b0;
        capture_s      = 1'b0;
        result_valid_s = 1'b0;
        case (state_r)
            IDLE: begin
                hash_ready_s = 1'b1;
                if (hash_valid_i) begin
                    next_state_s = ISSUE;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ISSUE: begin
                strobe_s     = 1'b1;
                next_state_s = ARM;
            end
            ARM: begin
                next_state_s = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (counter_done_i) begin
                    capture_s    = 1'b1;
                    next_state_s = COMPARE;
                end else begin
                    next_state_s = WAIT_DONE;
                end
            end
            COMPARE: begin
                result_valid_s = 1'b1;
                next_state_s   = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Best-record decision; a coincident clear makes the current result win
    always_comb begin
        accept_s = hash_ready_s & hash_valid_i;
        better_s = clear_best_i | ~best_valid_r | (result_bits_r < best_bits_r);
        if (result_valid_s) begin
            best_update_s = better_s;
        end else begin
            best_update_s = 1'b0;
        end
    end

    // Target register; an accept in the same cycle still sees the old value
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            target_r <= {HASH_W{1'b0}};
        end else if (target_load_i) begin
            target_r <= target_i;
        end else begin
            target_r <= target_r;
        end
    end

    // Accepted job: XOR result held until the next accept, plus its ID
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hash_xor_r <= {HASH_W{1'b0}};
            id_r       <= {ID_W{1'b0}};
        end else if (accept_s) begin
            hash_xor_r <= hash_i ^ target_r;
            id_r       <= hash_id_i;
        end else begin
            hash_xor_r <= hash_xor_r;
            id_r       <= id_r;
        end
    end

    // Counter result captured in the cycle done is first seen in WAIT_DONE
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            result_bits_r <= {BITS_W{1'b0}};
        end else if (capture_s) begin
            result_bits_r <= counter_bits_off_i;
        end else begin
            result_bits_r <= result_bits_r;
        end
    end

    // Best-so-far record
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            best_valid_r <= 1'b0;
            best_bits_r  <= {BITS_W{1'b1}};
            best_id_r    <= {ID_W{1'b0}};
        end else if (best_update_s) begin
            best_valid_r <= 1'b1;
            best_bits_r  <= result_bits_r;
            best_id_r    <= id_r;
        end else if (clear_best_i) begin
            best_valid_r <= 1'b0;
            best_bits_r  <= {BITS_W{1'b1}};
            best_id_r    <= {ID_W{1'b0}};
        end else begin
            best_valid_r <= best_valid_r;
            best_bits_r  <= best_bits_r;
            best_id_r    <= best_id_r;
        end
    end

    assign hash_ready_o      = hash_ready_s;
    assign new_hash_ready_o  = strobe_s;
    assign hash_xor_o        = hash_xor_r;
    assign result_valid_o    = result_valid_s;
    assign result_bits_off_o = result_bits_r;
    assign result_id_o       = id_r;
    assign best_valid_o      = best_valid_r;
    assign best_bits_off_o   = best_bits_r;
    assign best_id_o         = best_id_r;
    assign best_update_o     = best_update_s;

endmodule

// File: tb/tb_hash_bits_off_dispatcher.sv
// Bench for hash_bits_off_dispatcher: timeline-based reference model plus directed
// and randomized jobs against a simple bits-off counter model.
module tb_hash_bits_off_dispatcher;

    localparam int HW = 1024;
    localparam int IW = 64;
    localparam int BW = 10;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [HW-1:0] target_i;
    logic          target_load_i;
    logic [HW-1:0] hash_i;
    logic [IW-1:0] hash_id_i;
    logic          hash_valid_i;
    logic          hash_ready_o;
    logic [HW-1:0] hash_xor_o;
    logic          new_hash_ready_o;
    logic [BW-1:0] counter_bits_off_i;
    logic          counter_done_i;
    logic          result_valid_o;
    logic [BW-1:0] result_bits_off_o;
    logic [IW-1:0] result_id_o;
    logic          clear_best_i;
    logic          best_valid_o;
    logic [BW-1:0] best_bits_off_o;
    logic [IW-1:0] best_id_o;
    logic          best_update_o;

    hash_bits_off_dispatcher dut (
        .clk_i(clk), .rst_i(rst_i), .target_i(target_i), .target_load_i(target_load_i),
        .hash_i(hash_i), .hash_id_i(hash_id_i), .hash_valid_i(hash_valid_i),
        .hash_ready_o(hash_ready_o), .hash_xor_o(hash_xor_o), .new_hash_ready_o(new_hash_ready_o),
        .counter_bits_off_i(counter_bits_off_i), .counter_done_i(counter_done_i),
        .result_valid_o(result_valid_o), .result_bits_off_o(result_bits_off_o),
        .result_id_o(result_id_o), .clear_best_i(clear_best_i), .best_valid_o(best_valid_o),
        .best_bits_off_o(best_bits_off_o), .best_id_o(best_id_o), .best_update_o(best_update_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [HW-1:0] act, input logic [HW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [HW-1:0] rand_hash();
        logic [HW-1:0] r;
        for (int i = 0; i < HW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference model: job timeline (accept edge, done edge) and best record
    int            cyc = 0;
    bit            m_busy;
    int            m_a;
    int            m_d;
    logic [HW-1:0] m_xor;
    logic [HW-1:0] m_tgt;
    logic [IW-1:0] m_id;
    logic [BW-1:0] m_bits;
    bit            m_bv;
    logic [BW-1:0] m_bb;
    logic [IW-1:0] m_bid;
    int            n_res = 0;
    int            n_upd = 0;
    int            n_strobe = 0;
    logic [IW-1:0] upd_ids[$];
    int            e_edge;
    bit            busy_pre;
    logic [HW-1:0] old_t;
    bit            exp_rv;

    task automatic model_reset();
        m_busy = 1'b0; m_a = -10; m_d = -1;
        m_xor = '0; m_tgt = '0; m_id = '0; m_bits = '0;
        m_bv = 1'b0; m_bb = '1; m_bid = '0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            e_edge = cyc + 1;
            if (!rst_i) begin
                model_reset();
            end else begin
                busy_pre = m_busy;
                old_t = m_tgt;
                if (m_busy && m_d >= 0) begin
                    if (clear_best_i || !m_bv || m_bits < m_bb) begin
                        m_bv = 1'b1; m_bb = m_bits; m_bid = m_id;
                    end
                    m_busy = 1'b0;
                end else if (clear_best_i) begin
                    m_bv = 1'b0; m_bb = '1; m_bid = '0;
                end
                if (m_busy && m_d < 0 && e_edge >= m_a + 3 && counter_done_i) begin
                    m_d = e_edge;
                    m_bits = counter_bits_off_i;
                end
                if (!busy_pre && hash_valid_i) begin
                    m_busy = 1'b1; m_a = e_edge; m_d = -1;
                    m_xor = hash_i ^ old_t; m_id = hash_id_i;
                end
                if (target_load_i) m_tgt = target_i;
            end
            cyc = e_edge;
            @(negedge clk);
            #1;
            if (!rst_i) model_reset();
            exp_rv = m_busy && (m_d >= 0);
            chk("ready", hash_ready_o, !m_busy);
            chk("strobe", new_hash_ready_o, m_busy && (cyc == m_a));
            chk("xor", hash_xor_o, m_xor);
            chk("result_valid", result_valid_o, exp_rv);
            if (exp_rv) begin
                chk("result_bits", result_bits_off_o, m_bits);
                chk("result_id", result_id_o, m_id);
            end
            chk("best_update", best_update_o, exp_rv && (clear_best_i || !m_bv || m_bits < m_bb));
            chk("best_valid", best_valid_o, m_bv);
            chk("best_bits", best_bits_off_o, m_bb);
            chk("best_id", best_id_o, m_bid);
            if (result_valid_o) n_res++;
            if (new_hash_ready_o) n_strobe++;
            if (best_update_o) begin
                n_upd++;
                upd_ids.push_back(result_id_o);
            end
        end
    end

    // Counter model: done after job_lat cycles, or held high in stale mode
    bit            stale = 1'b0;
    int            job_lat = 1;
    logic [BW-1:0] job_bits = '0;
    int            cnt = 0;

    initial begin
        counter_done_i = 1'b0;
        counter_bits_off_i = '0;
        forever begin
            @(negedge clk);
            if (stale) begin
                counter_done_i = 1'b1;
                counter_bits_off_i = job_bits;
            end else if (new_hash_ready_o) begin
                counter_done_i = 1'b0;
                cnt = job_lat;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    counter_done_i = 1'b1;
                    counter_bits_off_i = job_bits;
                end
            end
        end
    end

    int            last_a, last_r, last_strobes;
    logic [HW-1:0] last_xor;
    logic [BW-1:0] last_bits;
    logic [IW-1:0] last_id;
    bit            got;

    task automatic random_side(input bit rnd);
        if (rnd) begin
            target_load_i = ($urandom_range(0, 7) == 0);
            target_i = rand_hash();
            clear_best_i = ($urandom_range(0, 11) == 0);
        end else begin
            target_load_i = 1'b0;
            clear_best_i = 1'b0;
        end
    endtask

    task automatic run_job(input logic [IW-1:0] id, input logic [HW-1:0] h, input logic [BW-1:0] bits,
                           input int lat, input bit load_now, input logic [HW-1:0] new_tgt,
                           input bit clr_cmp, input bit rnd);
        int w;
        job_bits = bits;
        job_lat = lat;
        got = 1'b0;
        w = 0;
        do begin
            @(negedge clk);
            random_side(rnd);
            w++;
        end while (!hash_ready_o && w < 100);
        chk("ready_wait", hash_ready_o, 1'b1);
        hash_valid_i = 1'b1;
        hash_i = h;
        hash_id_i = id;
        if (load_now) begin
            target_load_i = 1'b1;
            target_i = new_tgt;
        end
        @(negedge clk);
        hash_valid_i = 1'b0;
        hash_i = rand_hash();
        random_side(rnd);
        last_a = cyc;
        #2;
        last_xor = hash_xor_o;
        last_strobes = 0;
        for (int i = 0; i < lat + 100; i++) begin
            if (new_hash_ready_o) last_strobes++;
            if (result_valid_o) begin
                got = 1'b1;
                last_r = cyc;
                last_bits = result_bits_off_o;
                last_id = result_id_o;
                if (clr_cmp) begin
                    clear_best_i = 1'b1;
                    #1;
                    chk("clear_cmp_update", best_update_o, 1'b1);
                end
                break;
            end
            @(negedge clk);
            random_side(rnd);
            #2;
        end
        chk("job_done", got, 1'b1);
        @(negedge clk);
        random_side(1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    int            s0, u0, r0;
    logic [HW-1:0] t1, t2, h1, h2;

    initial begin
        rst_i = 1'b1;
        target_i = '0; target_load_i = 1'b0; hash_i = '0; hash_id_i = '0;
        hash_valid_i = 1'b0; clear_best_i = 1'b0;
        #1 rst_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_i = 1'b1;
        #2;
        chk("rst_ready", hash_ready_o, 1'b1);
        chk("rst_xor", hash_xor_o, '0);
        chk("rst_rbits", result_bits_off_o, 10'd0);
        chk("rst_rid", result_id_o, 64'd0);
        chk("rst_bbits", best_bits_off_o, 10'h3FF);
        chk("rst_bvalid", best_valid_o, 1'b0);
        s0 = n_strobe;
        repeat (20) @(negedge clk);
        chk("idle_strobes", n_strobe - s0, 0);

        // Single job against an all-ones target
        target_load_i = 1'b1; target_i = '1;
        @(negedge clk);
        target_load_i = 1'b0;
        run_job(64'd5, '0, 10'h3FF, 1030, 1'b0, '0, 1'b0, 1'b0);
        chk("single_xor", last_xor, {HW{1'b1}});
        chk("single_strobes", last_strobes, 1);
        chk("single_bits", last_bits, 10'h3FF);
        chk("single_id", last_id, 64'd5);
        #2 chk("single_bvalid", best_valid_o, 1'b1);

        // Best tracking with a tie
        @(negedge clk); clear_best_i = 1'b1;
        @(negedge clk); clear_best_i = 1'b0;
        u0 = n_upd;
        upd_ids.delete();
        run_job(64'd1, rand_hash(), 10'd300, 4, 1'b0, '0, 1'b0, 1'b0);
        run_job(64'd2, rand_hash(), 10'd120, 7, 1'b0, '0, 1'b0, 1'b0);
        run_job(64'd3, rand_hash(), 10'd120, 2, 1'b0, '0, 1'b0, 1'b0);
        run_job(64'd4, rand_hash(), 10'd400, 5, 1'b0, '0, 1'b0, 1'b0);
        chk("best_updates", n_upd - u0, 2);
        chk("best_upd_id0", upd_ids.size() > 0 ? upd_ids[0] : 64'hDEAD, 64'd1);
        chk("best_upd_id1", upd_ids.size() > 1 ? upd_ids[1] : 64'hDEAD, 64'd2);
        #2;
        chk("best_final_bits", best_bits_off_o, 10'd120);
        chk("best_final_id", best_id_o, 64'd2);

        // Stale done held high
        stale = 1'b1;
        run_job(64'd7, rand_hash(), 10'd55, 1, 1'b0, '0, 1'b0, 1'b0);
        chk("stale_latency", last_r - last_a, 3);
        chk("stale_bits", last_bits, 10'd55);
        #2;
        chk("stale_ready", hash_ready_o, 1'b1);
        chk("stale_ready_at", cyc - last_a, 4);
        stale = 1'b0;

        // Target load colliding with accept
        t1 = rand_hash(); t2 = rand_hash(); h1 = rand_hash(); h2 = rand_hash();
        @(negedge clk); target_load_i = 1'b1; target_i = t1;
        @(negedge clk); target_load_i = 1'b0;
        run_job(64'd8, h1, 10'd900, 3, 1'b1, t2, 1'b0, 1'b0);
        chk("collide_old_target", last_xor, h1 ^ t1);
        run_job(64'd12, h2, 10'd800, 3, 1'b0, '0, 1'b0, 1'b0);
        chk("collide_new_target", last_xor, h2 ^ t2);

        // Clear coinciding with COMPARE
        run_job(64'd9, rand_hash(), 10'd700, 5, 1'b0, '0, 1'b1, 1'b0);
        #2;
        chk("clear_cmp_valid", best_valid_o, 1'b1);
        chk("clear_cmp_bits", best_bits_off_o, 10'd700);
        chk("clear_cmp_id", best_id_o, 64'd9);

        // Reset during WAIT_DONE
        r0 = n_res;
        @(negedge clk);
        job_lat = 200;
        hash_valid_i = 1'b1; hash_i = rand_hash(); hash_id_i = 64'd10;
        @(negedge clk);
        hash_valid_i = 1'b0;
        repeat (10) @(negedge clk);
        rst_i = 1'b0;
        #2;
        chk("midrst_strobe", new_hash_ready_o, 1'b0);
        chk("midrst_ready", hash_ready_o, 1'b1);
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        #2;
        chk("midrst_bvalid", best_valid_o, 1'b0);
        chk("midrst_bbits", best_bits_off_o, 10'h3FF);
        repeat (5) @(negedge clk);
        run_job(64'd11, rand_hash(), 10'd77, 4, 1'b0, '0, 1'b0, 1'b0);
        chk("midrst_next_id", last_id, 64'd11);
        chk("midrst_next_bits", last_bits, 10'd77);
        chk("midrst_results", n_res - r0, 1);

        // Randomized jobs with background target loads and clears
        for (int j = 0; j < 40; j++) begin
            stale = ($urandom_range(0, 4) == 0);
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                random_side(1'b1);
            end
            run_job({$urandom, $urandom}, rand_hash(), BW'($urandom_range(0, 1023)),
                    $urandom_range(1, 12), 1'b0, '0, 1'b0, 1'b1);
        end
        stale = 1'b0;

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
